// File: rtl/vga_timing_pkg.sv
// Shared 640x480 VGA raster timing constants and the counter type.
// The background, sprite and colour-output stages take their window edges from here.
package vga_timing_pkg;

    localparam int CNT_W       = 10;

    localparam int H_TOTAL     = 800;
    localparam int H_PULSE     = 96;
    localparam int H_VIS_START = 144;
    localparam int H_VIS_END   = 784;

    localparam int V_TOTAL     = 521;
    localparam int V_PULSE     = 2;
    localparam int V_VIS_START = 31;
    localparam int V_VIS_END   = 511;

    typedef logic [CNT_W-1:0] cnt_t;

    // True when lo <= x < hi (half-open window, as used for the visible area).
    function automatic logic in_span(cnt_t x, int lo, int hi);
        return (int'(x) >= lo) && (int'(x) < hi);
    endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-rate divider: one pix_en pulse every CLK_DIV system clocks.
// o_pix_stb is the combinational terminal count so the parent can step its
// counters on the same edge that raises the registered o_pix_en.
module vga_pix_div #(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_pix_stb,
    output logic o_pix_en
);

    localparam int             DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] r_div_cnt;
    logic          r_pix_en;
    logic          w_last;

    assign w_last    = (r_div_cnt == DIV_LAST);
    assign o_pix_stb = w_last;
    assign o_pix_en  = r_pix_en;

    // Divider counter wraps at CLK_DIV-1; pix_en registers the terminal count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div_cnt <= '0;
            r_pix_en  <= 1'b0;
        end else begin
            r_pix_en  <= w_last;
            r_div_cnt <= w_last ? '0 : r_div_cnt + DW'(1);
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: h/v position, active-low syncs, visible flag and
// pixel/line/frame/animation tick enables. Syncs and video_on are registered
// from the next counter values so they line up with the presented position.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int H_TOTAL     = vga_timing_pkg::H_TOTAL,
    parameter int H_PULSE     = vga_timing_pkg::H_PULSE,
    parameter int H_VIS_START = vga_timing_pkg::H_VIS_START,
    parameter int H_VIS_END   = vga_timing_pkg::H_VIS_END,
    parameter int V_TOTAL     = vga_timing_pkg::V_TOTAL,
    parameter int V_PULSE     = vga_timing_pkg::V_PULSE,
    parameter int V_VIS_START = vga_timing_pkg::V_VIS_START,
    parameter int V_VIS_END   = vga_timing_pkg::V_VIS_END,
    parameter int ANIM_FRAMES = 60
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic [CNT_W-1:0] o_h_count,
    output logic [CNT_W-1:0] o_v_count,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_video_on,
    output logic             o_pix_en,
    output logic             o_line_tick,
    output logic             o_frame_tick,
    output logic             o_anim_tick
);

    localparam cnt_t          H_LAST  = cnt_t'(H_TOTAL - 1);
    localparam cnt_t          V_LAST  = cnt_t'(V_TOTAL - 1);
    localparam cnt_t          H_PLS   = cnt_t'(H_PULSE);
    localparam cnt_t          V_PLS   = cnt_t'(V_PULSE);
    localparam int            FW      = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
    localparam logic [FW-1:0] F_LAST  = FW'(ANIM_FRAMES - 1);

    logic          w_pix_stb;
    logic          w_h_wrap;
    logic          w_v_wrap;
    logic          w_line;
    logic          w_frame;
    logic          w_anim;
    cnt_t          w_h_nxt;
    cnt_t          w_v_nxt;

    cnt_t          r_h_count;
    cnt_t          r_v_count;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_video_on;
    logic          r_line_tick;
    logic          r_frame_tick;
    logic          r_anim_tick;
    logic [FW-1:0] r_frame_cnt;

    vga_pix_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_div (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .o_pix_stb (w_pix_stb),
        .o_pix_en  (o_pix_en)
    );

    assign w_h_wrap = (r_h_count == H_LAST);
    assign w_v_wrap = (r_v_count == V_LAST);
    assign w_line   = w_pix_stb & w_h_wrap;
    assign w_frame  = w_line & w_v_wrap;
    assign w_anim   = w_frame & (r_frame_cnt == F_LAST);

    // Next raster position: step h on a pixel strobe, step v on the h wrap.
    always_comb begin
        w_h_nxt = r_h_count;
        w_v_nxt = r_v_count;
        if (w_pix_stb) begin
            w_h_nxt = w_h_wrap ? '0 : r_h_count + cnt_t'(1);
            if (w_h_wrap) begin
                w_v_nxt = w_v_wrap ? '0 : r_v_count + cnt_t'(1);
            end
        end
    end

    // Register position, syncs/visible flag from the next position, and the ticks.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_h_count    <= '0;
            r_v_count    <= '0;
            r_hsync      <= 1'b0;
            r_vsync      <= 1'b0;
            r_video_on   <= 1'b0;
            r_line_tick  <= 1'b0;
            r_frame_tick <= 1'b0;
            r_anim_tick  <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_h_count    <= w_h_nxt;
            r_v_count    <= w_v_nxt;
            r_hsync      <= (w_h_nxt >= H_PLS);
            r_vsync      <= (w_v_nxt >= V_PLS);
            r_video_on   <= in_span(w_h_nxt, H_VIS_START, H_VIS_END) &&
                            in_span(w_v_nxt, V_VIS_START, V_VIS_END);
            r_line_tick  <= w_line;
            r_frame_tick <= w_frame;
            r_anim_tick  <= w_anim;
            if (w_frame) begin
                r_frame_cnt <= w_anim ? '0 : r_frame_cnt + FW'(1);
            end
        end
    end

    assign o_h_count    = r_h_count;
    assign o_v_count    = r_v_count;
    assign o_hsync      = r_hsync;
    assign o_vsync      = r_vsync;
    assign o_video_on   = r_video_on;
    assign o_line_tick  = r_line_tick;
    assign o_frame_tick = r_frame_tick;
    assign o_anim_tick  = r_anim_tick;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three instances (default timing, CLK_DIV=1, small
// raster with ANIM_FRAMES=2) each scored every clock against a closed-form
// model of the raster derived from the number of clocks since reset,
// plus directed checks at the timing boundaries.
module tb_vga_sync_gen;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       von;
        logic       pix;
        logic       lt;
        logic       ft;
        logic       at;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            if (n_errors <= 20)
                $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Position after n clocks since reset: s = n / CLK_DIV pixel steps taken.
    function automatic obs_t model(int n, int cd, int ht, int hp, int hvs, int hve,
                                   int vt, int vp, int vvs, int vve, int af);
        obs_t o;
        int s, h, l, v, fr;
        s = n / cd;
        h = s % ht;
        l = s / ht;
        v = l % vt;
        fr = l / vt;
        o.h   = 10'(h);
        o.v   = 10'(v);
        o.hs  = (h >= hp);
        o.vs  = (v >= vp);
        o.von = (h >= hvs) && (h < hve) && (v >= vvs) && (v < vve);
        o.pix = (n > 0) && (n % cd == 0);
        o.lt  = o.pix && (h == 0);
        o.ft  = o.lt && (v == 0);
        o.at  = o.ft && (fr % af == 0);
        return o;
    endfunction

    // ---------------- instance A: defaults ----------------
    logic a_rst = 1'b0;
    logic [9:0] a_h, a_v;
    logic a_hs, a_vs, a_von, a_pix, a_lt, a_ft, a_at;
    obs_t obs_a;
    assign obs_a = {a_h, a_v, a_hs, a_vs, a_von, a_pix, a_lt, a_ft, a_at};

    vga_sync_gen u_a (
        .i_clk(clk), .i_rst(a_rst),
        .o_h_count(a_h), .o_v_count(a_v), .o_hsync(a_hs), .o_vsync(a_vs),
        .o_video_on(a_von), .o_pix_en(a_pix), .o_line_tick(a_lt),
        .o_frame_tick(a_ft), .o_anim_tick(a_at)
    );

    // ---------------- instance B: CLK_DIV=1 ----------------
    logic b_rst = 1'b0;
    logic [9:0] b_h, b_v;
    logic b_hs, b_vs, b_von, b_pix, b_lt, b_ft, b_at;
    obs_t obs_b;
    assign obs_b = {b_h, b_v, b_hs, b_vs, b_von, b_pix, b_lt, b_ft, b_at};

    vga_sync_gen #(.CLK_DIV(1)) u_b (
        .i_clk(clk), .i_rst(b_rst),
        .o_h_count(b_h), .o_v_count(b_v), .o_hsync(b_hs), .o_vsync(b_vs),
        .o_video_on(b_von), .o_pix_en(b_pix), .o_line_tick(b_lt),
        .o_frame_tick(b_ft), .o_anim_tick(b_at)
    );

    // ---------------- instance C: small raster ----------------
    logic c_rst = 1'b0;
    logic [9:0] c_h, c_v;
    logic c_hs, c_vs, c_von, c_pix, c_lt, c_ft, c_at;
    obs_t obs_c;
    assign obs_c = {c_h, c_v, c_hs, c_vs, c_von, c_pix, c_lt, c_ft, c_at};

    vga_sync_gen #(
        .CLK_DIV(2), .H_TOTAL(20), .H_PULSE(3), .H_VIS_START(5), .H_VIS_END(15),
        .V_TOTAL(12), .V_PULSE(2), .V_VIS_START(3), .V_VIS_END(10), .ANIM_FRAMES(2)
    ) u_c (
        .i_clk(clk), .i_rst(c_rst),
        .o_h_count(c_h), .o_v_count(c_v), .o_hsync(c_hs), .o_vsync(c_vs),
        .o_video_on(c_von), .o_pix_en(c_pix), .o_line_tick(c_lt),
        .o_frame_tick(c_ft), .o_anim_tick(c_at)
    );

    // ---------------- scoreboards ----------------
    bit en_a = 0, en_b = 0, en_c = 0;
    int na = 0, nb = 0, nc = 0;
    obs_t q_a[$], q_b[$], q_c[$];

    // Push the expected post-edge state for the reset value applied at this edge.
    always @(posedge clk) begin
        if (en_a) q_a.push_back(model(a_rst ? 0 : na + 1, 4, 800, 96, 144, 784, 521, 2, 31, 511, 60));
        if (en_b) q_b.push_back(model(b_rst ? 0 : nb + 1, 1, 800, 96, 144, 784, 521, 2, 31, 511, 60));
        if (en_c) q_c.push_back(model(c_rst ? 0 : nc + 1, 2, 20, 3, 5, 15, 12, 2, 3, 10, 2));
        na <= a_rst ? 0 : na + 1;
        nb <= b_rst ? 0 : nb + 1;
        nc <= c_rst ? 0 : nc + 1;
    end

    // Compare mid-cycle, away from the active edge.
    always @(negedge clk) begin : sb_cmp
        obs_t e;
        if (q_a.size() > 0) begin e = q_a.pop_front(); chk("A.sb", obs_a, e); end
        if (q_b.size() > 0) begin e = q_b.pop_front(); chk("B.sb", obs_b, e); end
        if (q_c.size() > 0) begin e = q_c.pop_front(); chk("C.sb", obs_c, e); end
    end

    task automatic wait_a(input int h, input int v, input int budget, output bit ok);
        ok = 0;
        for (int k = 0; k < budget; k++) begin
            if (a_h == 10'(h) && a_v == 10'(v)) begin ok = 1; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_b(input int h, input int v, input int budget, output bit ok);
        ok = 0;
        for (int k = 0; k < budget; k++) begin
            if (b_h == 10'(h) && b_v == 10'(v)) begin ok = 1; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_c(input int h, input int v, input int budget, output bit ok);
        ok = 0;
        for (int k = 0; k < budget; k++) begin
            if (c_h == 10'(h) && c_v == 10'(v)) begin ok = 1; break; end
            @(negedge clk);
        end
    endtask

    task automatic run_a();
        bit ok;
        a_rst = 1'b1;
        en_a  = 1;
        repeat (3) @(negedge clk);
        a_rst = 1'b0;
        chk("A.reset_state", obs_a, 32'd0);
        repeat (3) @(negedge clk);
        chk("A.pre_first_pix", {a_pix, a_h}, {1'b0, 10'd0});
        @(negedge clk);
        chk("A.first_pix", {a_pix, a_h}, {1'b1, 10'd1});
        @(negedge clk);
        chk("A.pix_one_clk", {a_pix, a_h}, {1'b0, 10'd1});
        repeat (3) @(negedge clk);
        chk("A.h_step4", {a_pix, a_h}, {1'b1, 10'd2});
        wait_a(95, 0, 500, ok);
        chk("A.reach_95", ok, 1);
        chk("A.hsync_95", a_hs, 0);
        wait_a(96, 0, 8, ok);
        chk("A.reach_96", ok, 1);
        chk("A.hsync_96", a_hs, 1);
        wait_a(799, 0, 3000, ok);
        chk("A.reach_799", ok, 1);
        chk("A.hsync_799", a_hs, 1);
        wait_a(0, 1, 8, ok);
        chk("A.line_wrap", ok, 1);
        chk("A.wrap_hs_lt_ft", {a_hs, a_lt, a_ft, a_vs}, {1'b0, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        chk("A.line_tick_one_clk", {a_lt, a_h, a_v}, {1'b0, 10'd0, 10'd1});
    endtask

    task automatic run_b();
        bit ok;
        b_rst = 1'b1;
        en_b  = 1;
        repeat (2) @(negedge clk);
        b_rst = 1'b0;
        @(negedge clk);
        chk("B.pix_first", {b_pix, b_h}, {1'b1, 10'd1});
        @(negedge clk);
        chk("B.pix_every_clk", {b_pix, b_h}, {1'b1, 10'd2});
        wait_b(143, 31, 26000, ok);
        chk("B.reach_143_31", ok, 1);
        chk("B.von_143_31", b_von, 0);
        @(negedge clk);
        chk("B.von_144_31", {b_von, b_h}, {1'b1, 10'd144});
        wait_b(783, 31, 700, ok);
        chk("B.reach_783_31", ok, 1);
        chk("B.von_783_31", b_von, 1);
        @(negedge clk);
        chk("B.von_784_31", {b_von, b_h}, {1'b0, 10'd784});
    endtask

    task automatic run_c();
        bit ok;
        int th[5] = '{4, 5, 14, 15, 5};
        int tv[5] = '{3, 3, 9, 9, 10};
        int te[5] = '{0, 1, 1, 0, 0};
        int nft, nat, k;
        c_rst = 1'b1;
        en_c  = 1;
        repeat (2) @(negedge clk);
        c_rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_c(th[i], tv[i], 600, ok);
            chk("C.vis_reach", ok, 1);
            chk("C.video_on", c_von, 32'(te[i]));
        end
        k = 0;
        while (!c_ft && k < 600) begin @(negedge clk); k++; end
        chk("C.frame_wrap_pos", {c_h, c_v, c_lt, c_vs, c_at}, {10'd0, 10'd0, 1'b1, 1'b0, 1'b0});
        wait_c(19, 1, 100, ok);
        chk("C.reach_19_1", ok, 1);
        chk("C.vsync_v1", c_vs, 0);
        wait_c(0, 2, 4, ok);
        chk("C.reach_0_2", ok, 1);
        chk("C.vsync_v2", c_vs, 1);
        nft = 0;
        nat = 0;
        for (int i = 0; i < 1920; i++) begin
            @(negedge clk);
            nft += int'(c_ft);
            nat += int'(c_at);
        end
        chk("C.frame_ticks_4f", nft, 4);
        chk("C.anim_ticks_4f", nat, 2);
        wait_c(10, 6, 600, ok);
        chk("C.reach_10_6", ok, 1);
        c_rst = 1'b1;
        @(negedge clk);
        c_rst = 1'b0;
        chk("C.mid_reset", obs_c, 32'd0);
        k = 0;
        while (!c_at && k < 1500) begin @(negedge clk); k++; end
        chk("C.anim_after_reset_clks", k, 960);
    endtask

    initial begin
        fork
            run_a();
            run_b();
            run_c();
        join
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
